// File: rtl/seq_scan_ctrl.sv
// Word-to-serial pattern scanner: accepts words over valid/ready, shifts them MSB-first
// into a history register, and counts overlapping pattern matches. Optional irq: SEQ_SCAN_IRQ_EN.
module seq_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              irq_ack,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int BC_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [1:0]        state;
    logic [WORD_W-1:0] word_sr;
    logic [BC_W-1:0]   bit_cnt;
    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic              shifting;
    logic              last_bit;
    logic              match;
    logic              cnt_sat;

    always_comb begin
        shifting  = (state == ST_SHIFT);
        last_bit  = (bit_cnt == BC_W'(WORD_W - 1));
        hist_next = {history[PAT_W-2:0], word_sr[WORD_W-1]};
        fill_next = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
        // fill_next reaching PAT_W guarantees the history holds only real bits
        match     = shifting && (hist_next == pattern) && (fill_next == FILL_W'(PAT_W));
        cnt_sat   = &match_cnt;
    end

    assign in_ready = (state == ST_ACCEPT);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            word_sr <= '0;
            bit_cnt <= '0;
            pattern <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state   <= ST_ACCEPT;
                        pattern <= cfg_pattern;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        word_sr <= in_data;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    word_sr <= word_sr << 1;
                    bit_cnt <= bit_cnt + BC_W'(1);
                    if (last_bit) begin
                        state <= en ? ST_ACCEPT : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // clr wipes match history but leaves the word in flight to keep shifting
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            history     <= '0;
            fill        <= '0;
            match_cnt   <= '0;
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= match;
            if (shifting) begin
                history <= hist_next;
                fill    <= fill_next;
            end
            if (match && !cnt_sat) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_SCAN_IRQ_EN
    logic irq_set;

    assign irq_set = match && !cnt_sat && (cfg_thresh != '0) &&
                     ((match_cnt + CNT_W'(1)) == cfg_thresh);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            irq <= 1'b0;
        end else if (irq_set) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{cfg_thresh, irq_ack};
    assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed scenarios plus random traffic, checked every cycle
// against a bit-queue reference model; a second instance uses a 3-bit counter.
module tb_seq_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int PAT_W  = 5;
    localparam int CNT_W  = 16;
    localparam int S_MAX  = 7;
    localparam int B_MAX  = 65535;
`ifdef SEQ_SCAN_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, en, clr, irq_ack, in_valid;
    logic [PAT_W-1:0]  cfg_pattern;
    logic [CNT_W-1:0]  cfg_thresh;
    logic [WORD_W-1:0] in_data;

    logic              in_ready, busy, match_pulse, irq;
    logic [CNT_W-1:0]  match_cnt;
    logic              s_in_ready, s_busy, s_match_pulse, s_irq;
    logic [2:0]        s_match_cnt;

    seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_pattern(cfg_pattern),
        .cfg_thresh(cfg_thresh), .irq_ack(irq_ack), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse),
        .match_cnt(match_cnt), .irq(irq)
    );

    seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_pattern(cfg_pattern),
        .cfg_thresh(cfg_thresh[2:0]), .irq_ack(irq_ack), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .busy(s_busy), .match_pulse(s_match_pulse),
        .match_cnt(s_match_cnt), .irq(s_irq)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 waiting for a word, 2 serialising
    int               m_mode;
    int               m_left;
    logic [WORD_W-1:0] m_word;
    bit               m_bits[$];
    int               m_fill;
    logic [PAT_W-1:0] m_pat;
    int               m_cnt;
    bit               m_pulse, m_irq, m_irq_s;

    int checks = 0;
    int errors = 0;
    int pulses_seen = 0;

    function automatic logic [PAT_W-1:0] hist_val();
        logic [PAT_W-1:0] h = '0;
        foreach (m_bits[k]) h = {h[PAT_W-2:0], m_bits[k]};
        return h;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_edge();
        bit match;
        int b_old, b_new, s_old, s_new;
        bit set_b, set_s;
        if (rst) begin
            m_mode = 0; m_left = 0; m_word = '0; m_bits.delete(); m_fill = 0;
            m_pat = '0; m_cnt = 0; m_pulse = 0; m_irq = 0; m_irq_s = 0;
            return;
        end
        match = 0;
        case (m_mode)
            0: if (en) begin m_mode = 1; m_pat = cfg_pattern; end
            1: if (in_valid) begin m_word = in_data; m_left = WORD_W; m_mode = 2; end
            default: begin
                m_bits.push_back(m_word[m_left-1]);
                m_left--;
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                if (m_fill < PAT_W) m_fill++;
                match = (m_fill == PAT_W) && (hist_val() == m_pat);
                if (m_left == 0) m_mode = en ? 1 : 0;
            end
        endcase
        b_old = sat(m_cnt, B_MAX);
        s_old = sat(m_cnt, S_MAX);
        m_pulse = match;
        if (match) m_cnt++;
        b_new = sat(m_cnt, B_MAX);
        s_new = sat(m_cnt, S_MAX);
        set_b = IRQ_ON && match && (b_new != b_old) && (b_new == int'(cfg_thresh)) && (cfg_thresh != 0);
        set_s = IRQ_ON && match && (s_new != s_old) && (s_new == int'(cfg_thresh[2:0])) && (cfg_thresh[2:0] != 0);
        if (clr) begin
            m_bits.delete(); m_fill = 0; m_cnt = 0; m_pulse = 0; m_irq = 0; m_irq_s = 0;
        end else begin
            if (set_b) m_irq = 1; else if (irq_ack) m_irq = 0;
            if (set_s) m_irq_s = 1; else if (irq_ack) m_irq_s = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_mode == 1});
        chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
        chk("match_pulse", {31'd0, match_pulse}, {31'd0, m_pulse});
        chk("match_cnt", {16'd0, match_cnt}, sat(m_cnt, B_MAX));
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        chk("s_in_ready", {31'd0, s_in_ready}, {31'd0, m_mode == 1});
        chk("s_busy", {31'd0, s_busy}, {31'd0, m_mode != 0});
        chk("s_match_pulse", {31'd0, s_match_pulse}, {31'd0, m_pulse});
        chk("s_match_cnt", {29'd0, s_match_cnt}, sat(m_cnt, S_MAX));
        chk("s_irq", {31'd0, s_irq}, {31'd0, m_irq_s});
        pulses_seen += int'(match_pulse);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Offers a word, then runs its WORD_W shift edges; events fire on shift edge N (1-based).
    task automatic send_word(input logic [WORD_W-1:0] w, input int clr_at, input int endrop_at,
                             input int rst_at, input bit hold_valid);
        in_data  = w;
        in_valid = 1'b1;
        for (int k = 0; k < 4 && m_mode != 2; k++) step();
        chk("accept_bound", m_mode, 2);
        if (!hold_valid) in_valid = 1'b0;
        for (int i = 1; i <= WORD_W; i++) begin
            if (i == clr_at) clr = 1'b1;
            if (i == endrop_at) en = 1'b0;
            if (i == rst_at) rst = 1'b1;
            step();
            clr = 1'b0;
            if (rst) begin
                rst = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int p0;
        rst = 1'b1; en = 1'b0; clr = 1'b0; irq_ack = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_pattern = 5'b10110; cfg_thresh = 16'd2;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_cnt", {16'd0, match_cnt}, 0);

        // Overlapping matches inside one word
        en = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        p0 = pulses_seen;
        send_word(8'b1011_0110, -1, -1, -1, 1'b0);
        chk("t1_pulses", pulses_seen - p0, 2);
        chk("t1_cnt", {16'd0, match_cnt}, 2);
        chk("t6_irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t6_irq_ack", {31'd0, irq}, 0);

        // Match spanning a word boundary
        clr = 1'b1;
        step();
        clr = 1'b0;
        p0 = pulses_seen;
        send_word(8'h05, -1, -1, -1, 1'b0);
        send_word(8'h80, -1, -1, -1, 1'b0);
        chk("t2_pulses", pulses_seen - p0, 1);
        chk("t2_cnt", {16'd0, match_cnt}, 1);

        // All-zero pattern: fill gating and 3-bit saturation
        rst = 1'b1;
        step();
        rst = 1'b0; cfg_pattern = 5'b00000;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        send_word(8'h00, -1, -1, -1, 1'b0);
        chk("t3_cnt_first", {16'd0, match_cnt}, 4);
        send_word(8'h00, -1, -1, -1, 1'b0);
        chk("t3_cnt_second", {16'd0, match_cnt}, 12);
        chk("t3_cnt_sat", {29'd0, s_match_cnt}, 7);

        // en dropped mid-word with in_valid held
        cfg_pattern = 5'b10110;
        send_word(8'hB6, -1, 3, -1, 1'b1);
        step(); step(); step();
        chk("t4_idle_ready", {31'd0, in_ready}, 0);
        chk("t4_idle_busy", {31'd0, busy}, 0);
        en = 1'b1;
        step();
        chk("t4_reaccept", {31'd0, in_ready}, 1);
        step();
        chk("t4_taken", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        repeat (WORD_W) step();

        // clr on a match edge, then rst mid-word
        clr = 1'b1;
        step();
        clr = 1'b0;
        send_word(8'hB6, 5, -1, -1, 1'b0);
        chk("t5_clr_cnt", {16'd0, match_cnt}, 0);
        send_word(8'hFF, -1, -1, 3, 1'b0);
        chk("t5_rst_ready", {31'd0, in_ready}, 0);
        chk("t5_rst_busy", {31'd0, busy}, 0);
        chk("t5_rst_cnt", {16'd0, match_cnt}, 0);
        chk("t5_rst_pulse", {31'd0, match_pulse}, 0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: cfg_pattern = 5'b10110;
                1: cfg_pattern = 5'b00000;
                2: cfg_pattern = 5'b11111;
                default: cfg_pattern = 5'($urandom);
            endcase
            cfg_thresh = 16'($urandom_range(0, 9));
            en       = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 40) == 0);
            irq_ack  = ($urandom_range(0, 6) == 0);
            rst      = ($urandom_range(0, 250) == 0);
            in_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: in_data = 8'hB6;
                1: in_data = 8'h00;
                2: in_data = 8'hFF;
                default: in_data = 8'($urandom);
            endcase
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
